// File: rtl/sort_result_streamer.sv
// Ping-pong frame buffer between the sorter's wide parallel output and a
// one-word-per-cycle valid/ready stream; drops and counts frames when both banks are busy.
module sort_result_streamer #(
  parameter int LOG_INPUT  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int REVERSE    = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  y_valid,
  input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0]  y,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [DATA_WIDTH-1:0]                 m_data,
  output logic [LOG_INPUT-1:0]                  m_index,
  output logic                                  m_last,
  output logic                                  overflow,
  output logic [7:0]                            drop_count,
  output logic                                  busy
);

  localparam int N = 2 ** LOG_INPUT;
  localparam logic [LOG_INPUT-1:0] FIRST_IDX = (REVERSE != 0) ? LOG_INPUT'(N - 1) : '0;
  localparam logic [LOG_INPUT-1:0] LAST_IDX  = (REVERSE != 0) ? '0 : LOG_INPUT'(N - 1);
  localparam logic                 ONE_WORD  = (N == 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              full_reg, full_next;
  logic                    wr_sel_reg, wr_sel_next;
  logic                    rd_sel_reg, rd_sel_next;
  logic                    m_valid_reg, m_valid_next;
  logic [DATA_WIDTH-1:0]   m_data_reg, m_data_next;
  logic [LOG_INPUT-1:0]    m_index_reg, m_index_next;
  logic                    m_last_reg, m_last_next;
  logic                    overflow_reg, overflow_next;
  logic [7:0]              drop_count_reg, drop_count_next;

  logic [DATA_WIDTH-1:0]   bank_mem [0:1][0:N-1];
  logic [DATA_WIDTH-1:0]   y_word   [0:N-1];

  logic                    handshake, release_beat, accept, capture, drop;
  logic [LOG_INPUT-1:0]    next_idx;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign y_word[gi] = y[DATA_WIDTH*gi +: DATA_WIDTH];
    end
  endgenerate

  // A full bank can still take a frame if its last beat leaves on this very edge.
  assign handshake    = (state_reg == STREAM) && m_ready;
  assign release_beat = handshake && m_last_reg;
  assign accept       = !full_reg[wr_sel_reg] || (release_beat && (wr_sel_reg == rd_sel_reg));
  assign capture      = y_valid && accept;
  assign drop         = y_valid && !accept;
  assign next_idx     = (REVERSE != 0) ? m_index_reg - 1'b1 : m_index_reg + 1'b1;

  always_comb begin
    state_next      = state_reg;
    full_next       = full_reg;
    wr_sel_next     = wr_sel_reg;
    rd_sel_next     = rd_sel_reg;
    m_valid_next    = m_valid_reg;
    m_data_next     = m_data_reg;
    m_index_next    = m_index_reg;
    m_last_next     = m_last_reg;
    overflow_next   = overflow_reg;
    drop_count_next = drop_count_reg;

    if (release_beat) full_next[rd_sel_reg] = 1'b0;
    if (capture) begin
      full_next[wr_sel_reg] = 1'b1;
      wr_sel_next           = ~wr_sel_reg;
    end
    if (drop) begin
      overflow_next = 1'b1;
      if (drop_count_reg != 8'hFF) drop_count_next = drop_count_reg + 8'd1;
    end

    case (state_reg)
      IDLE: begin
        if (full_reg[rd_sel_reg]) begin
          m_data_next  = bank_mem[rd_sel_reg][FIRST_IDX];
          m_index_next = FIRST_IDX;
          m_last_next  = ONE_WORD;
          m_valid_next = 1'b1;
          state_next   = STREAM;
        end
      end
      STREAM: begin
        if (handshake && !m_last_reg) begin
          m_data_next  = bank_mem[rd_sel_reg][next_idx];
          m_index_next = next_idx;
          m_last_next  = (next_idx == LAST_IDX);
        end else if (release_beat) begin
          rd_sel_next = ~rd_sel_reg;
          // Next frame either already waits or lands right now (read it straight off y).
          if (full_reg[~rd_sel_reg]) begin
            m_data_next  = bank_mem[~rd_sel_reg][FIRST_IDX];
            m_index_next = FIRST_IDX;
            m_last_next  = ONE_WORD;
          end else if (capture && (wr_sel_reg != rd_sel_reg)) begin
            m_data_next  = y_word[FIRST_IDX];
            m_index_next = FIRST_IDX;
            m_last_next  = ONE_WORD;
          end else begin
            m_valid_next = 1'b0;
            m_last_next  = 1'b0;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      full_reg       <= '0;
      wr_sel_reg     <= 1'b0;
      rd_sel_reg     <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= '0;
      m_index_reg    <= '0;
      m_last_reg     <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      full_reg       <= full_next;
      wr_sel_reg     <= wr_sel_next;
      rd_sel_reg     <= rd_sel_next;
      m_valid_reg    <= m_valid_next;
      m_data_reg     <= m_data_next;
      m_index_reg    <= m_index_next;
      m_last_reg     <= m_last_next;
      overflow_reg   <= overflow_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // Frame storage carries no reset; the full flags alone say what is valid.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N; i++) bank_mem[wr_sel_reg][i] <= y_word[i];
    end
  end

  assign m_valid    = m_valid_reg;
  assign m_data     = m_data_reg;
  assign m_index    = m_index_reg;
  assign m_last     = m_last_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;
  assign busy       = (|full_reg) || m_valid_reg;

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed/random bench for sort_result_streamer: a frame-queue scoreboard predicts
// every streamed beat plus overflow, drop_count and busy.
module tb_sort_result_streamer;
  localparam int LOG = 5;
  localparam int N   = 32;
  localparam int DW  = 32;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [LOG-1:0] idx;
    logic           last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            y_valid_drv = 1'b0;
  logic            use_rev = 1'b0;
  logic [DW*N-1:0] y_drv = '0;
  logic            m_ready_drv = 1'b0;

  logic y_valid_0, y_valid_r;
  logic m_valid_0, m_last_0, overflow_0, busy_0;
  logic m_valid_r, m_last_r, overflow_r, busy_r;
  logic [DW-1:0] m_data_0, m_data_r;
  logic [LOG-1:0] m_index_0, m_index_r;
  logic [7:0] drop_count_0, drop_count_r;

  logic obs_valid, obs_last, obs_ovf, obs_busy;
  logic [DW-1:0] obs_data;
  logic [LOG-1:0] obs_index;
  logic [7:0] obs_drops;

  always #5 clk = ~clk;

  assign y_valid_0 = y_valid_drv & ~use_rev;
  assign y_valid_r = y_valid_drv & use_rev;
  assign obs_valid = use_rev ? m_valid_r    : m_valid_0;
  assign obs_data  = use_rev ? m_data_r     : m_data_0;
  assign obs_index = use_rev ? m_index_r    : m_index_0;
  assign obs_last  = use_rev ? m_last_r     : m_last_0;
  assign obs_ovf   = use_rev ? overflow_r   : overflow_0;
  assign obs_drops = use_rev ? drop_count_r : drop_count_0;
  assign obs_busy  = use_rev ? busy_r       : busy_0;

  sort_result_streamer #(.LOG_INPUT(LOG), .DATA_WIDTH(DW), .REVERSE(0)) dut (
    .clk(clk), .rst(rst), .y_valid(y_valid_0), .y(y_drv),
    .m_valid(m_valid_0), .m_ready(m_ready_drv), .m_data(m_data_0), .m_index(m_index_0),
    .m_last(m_last_0), .overflow(overflow_0), .drop_count(drop_count_0), .busy(busy_0));

  sort_result_streamer #(.LOG_INPUT(LOG), .DATA_WIDTH(DW), .REVERSE(1)) dut_r (
    .clk(clk), .rst(rst), .y_valid(y_valid_r), .y(y_drv),
    .m_valid(m_valid_r), .m_ready(m_ready_drv), .m_data(m_data_r), .m_index(m_index_r),
    .m_last(m_last_r), .overflow(overflow_r), .drop_count(drop_count_r), .busy(busy_r));

  // Reference model: ordered list of expected beats, frames held, drop bookkeeping.
  beat_t        exp_q[$];
  int           held = 0;
  int           drops_m = 0;
  logic         ovf_m = 1'b0;
  logic [DW-1:0] fr [N];
  int           checks = 0, passes = 0, fails = 0;
  int           hs_count = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load_frame_desc();
    for (int i = 0; i < N; i++) fr[i] = DW'(N - i);
    for (int i = 0; i < N; i++) y_drv[DW*i +: DW] = fr[i];
  endtask

  task automatic load_frame_rand();
    for (int i = 0; i < N; i++) fr[i] = $urandom;
    for (int i = 0; i < N; i++) y_drv[DW*i +: DW] = fr[i];
  endtask

  task automatic push_frame();
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b.idx  = LOG'(use_rev ? N - 1 - k : k);
      b.data = fr[b.idx];
      b.last = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: score the beat (if any) about to handshake, apply the frame rule, advance.
  task automatic tick();
    beat_t b;
    logic  rel;
    rel = 1'b0;
    if (obs_valid && m_ready_drv) begin
      hs_count++;
      if (exp_q.size() == 0) chk("spurious_beat", 64'(obs_valid), 64'd0);
      else begin
        b = exp_q.pop_front();
        chk("m_data", 64'(obs_data), 64'(b.data));
        chk("m_index", 64'(obs_index), 64'(b.idx));
        chk("m_last", 64'(obs_last), 64'(b.last));
        rel = b.last;
      end
    end
    if (y_valid_drv) begin
      if (held < 2 || rel) begin
        push_frame();
        held++;
      end else begin
        ovf_m = 1'b1;
        if (drops_m != 255) drops_m++;
      end
    end
    if (rel) held--;
    @(posedge clk);
    #1;
    y_valid_drv = 1'b0;
    cyc++;
    chk("overflow", 64'(obs_ovf), 64'(ovf_m));
    chk("drop_count", 64'(obs_drops), 64'(drops_m));
    chk("busy", 64'(obs_busy), 64'(held != 0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    y_valid_drv = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    held = 0; drops_m = 0; ovf_m = 1'b0;
    chk("rst_m_valid", 64'(obs_valid), 64'd0);
    chk("rst_m_data", 64'(obs_data), 64'd0);
    chk("rst_m_index", 64'(obs_index), 64'd0);
    chk("rst_m_last", 64'(obs_last), 64'd0);
    chk("rst_overflow", 64'(obs_ovf), 64'd0);
    chk("rst_drop_count", 64'(obs_drops), 64'd0);
    chk("rst_busy", 64'(obs_busy), 64'd0);
  endtask

  task automatic drain(input bit pattern);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      m_ready_drv = pattern ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
      tick();
      n++;
    end
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int hs0, n;
    bit sent;

    // Single descending frame, forward order, with latency check.
    do_reset();
    load_frame_desc();
    m_ready_drv = 1'b1;
    y_valid_drv = 1'b1;
    tick();
    chk("latency_edge_k", 64'(obs_valid), 64'd0);
    tick();
    chk("latency_edge_k1", 64'(obs_valid), 64'd1);
    chk("first_word_fwd", 64'(obs_data), 64'd32);
    drain(1'b0);
    chk("end_m_valid", 64'(obs_valid), 64'd0);

    // Same frame through the REVERSE instance.
    use_rev = 1'b1;
    do_reset();
    load_frame_desc();
    y_valid_drv = 1'b1;
    tick();
    tick();
    chk("first_word_rev", 64'(obs_data), 64'd1);
    chk("first_index_rev", 64'(obs_index), 64'd31);
    drain(1'b0);
    chk("rev_end_m_valid", 64'(obs_valid), 64'd0);
    use_rev = 1'b0;

    // Random frame with m_ready pattern 1,0,0,1.
    do_reset();
    load_frame_rand();
    y_valid_drv = 1'b1;
    tick();
    drain(1'b1);

    // Capacity: three frames while stalled, third one dropped; then A,B back-to-back.
    m_ready_drv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10 || i == 20 || i == 30) begin
        load_frame_rand();
        y_valid_drv = 1'b1;
      end
      tick();
    end
    chk("cap_drop_count", 64'(obs_drops), 64'd1);
    chk("cap_overflow", 64'(obs_ovf), 64'd1);
    m_ready_drv = 1'b1;
    hs0 = hs_count;
    repeat (2 * N) tick();
    chk("cap_no_gap_beats", 64'(hs_count - hs0), 64'(2 * N));
    chk("cap_queue_empty", 64'(exp_q.size()), 64'd0);
    tick();
    chk("cap_end_valid", 64'(obs_valid), 64'd0);

    // Reset at beat 5 of a frame, sticky flags set beforehand.
    load_frame_rand();
    y_valid_drv = 1'b1;
    tick();
    hs0 = hs_count;
    n = 0;
    while (hs_count - hs0 < 5 && n < 50) begin tick(); n++; end
    chk("mid_frame_beats", 64'(hs_count - hs0), 64'd5);
    do_reset();
    load_frame_rand();
    y_valid_drv = 1'b1;
    tick();
    drain(1'b0);

    // B arrives on A's last beat while C occupies the other bank.
    do_reset();
    m_ready_drv = 1'b0;
    load_frame_rand(); y_valid_drv = 1'b1; tick();
    tick(); tick();
    load_frame_rand(); y_valid_drv = 1'b1; tick();
    tick();
    m_ready_drv = 1'b1;
    hs0 = hs_count;
    sent = 1'b0;
    for (int t = 0; t < 3 * N; t++) begin
      if (!sent && obs_valid && exp_q.size() == N + 1) begin
        load_frame_rand();
        y_valid_drv = 1'b1;
        sent = 1'b1;
      end
      tick();
    end
    chk("refill_sent", 64'(sent), 64'd1);
    chk("refill_beats", 64'(hs_count - hs0), 64'(3 * N));
    chk("refill_drop_count", 64'(obs_drops), 64'd0);
    chk("refill_queue_empty", 64'(exp_q.size()), 64'd0);

    // Next frame arriving on the last beat into the empty bank streams with no bubble.
    do_reset();
    load_frame_rand(); y_valid_drv = 1'b1; tick();
    tick();
    hs0 = hs_count;
    sent = 1'b0;
    for (int t = 0; t < 2 * N; t++) begin
      if (!sent && obs_valid && exp_q.size() == 1) begin
        load_frame_rand();
        y_valid_drv = 1'b1;
        sent = 1'b1;
      end
      tick();
    end
    chk("bypass_sent", 64'(sent), 64'd1);
    chk("bypass_beats", 64'(hs_count - hs0), 64'(2 * N));
    chk("bypass_queue_empty", 64'(exp_q.size()), 64'd0);

    // drop_count saturation.
    do_reset();
    m_ready_drv = 1'b0;
    for (int i = 0; i < 260; i++) begin
      load_frame_rand();
      y_valid_drv = 1'b1;
      tick();
    end
    chk("drop_saturated", 64'(obs_drops), 64'd255);
    drain(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sort_result_streamer.md
Name: sort_result_streamer

Overview:
Reader end of the sorter's wide output interface. Captures each complete sorted frame (2**LOG_INPUT words presented in parallel on y with a one-cycle y_valid strobe) into a two-bank ping-pong buffer. Replays each frame as a one-word-per-cycle valid/ready stream for downstream logic. The sorter has no backpressure, so the block absorbs stalls and reports frames it has to drop.

Parameters:
LOG_INPUT, 5, log2 of words per frame (N = 2**LOG_INPUT)
DATA_WIDTH, 32, bits per word
REVERSE, 0, 0 = emit word 0 first; 1 = emit word N-1 first

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
y_valid  in  1  one-cycle strobe: y holds a complete sorted frame
y  in  DATA_WIDTH*N  frame; word i = y[DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
m_valid  out  1  stream word valid (registered)
m_ready  in  1  downstream accepts word when m_valid & m_ready
m_data  out  DATA_WIDTH  current word (registered)
m_index  out  LOG_INPUT  index i of the current word
m_last  out  1  high on the final beat of a frame
overflow  out  1  sticky; set when a frame is dropped
drop_count  out  8  frames dropped, saturates at 255
busy  out  1  high when any bank is full or m_valid is high

Behaviour:
- Reset: m_valid, m_data, m_index, m_last, overflow, drop_count, busy = 0. Both bank-full flags cleared; wr_sel = rd_sel = 0; FSM = IDLE. Reset mid-frame discards all buffered and partially streamed data.
- Storage: bank[0..1], each N x DATA_WIDTH, plus full[0..1].
- Capture: y_valid at edge k with accept true writes y into bank[wr_sel], sets full[wr_sel] and toggles wr_sel.
  - accept = !full[wr_sel] OR (release AND wr_sel == rd_sel).
  - release = the last beat of a frame handshakes at this edge.
  - A bank freed on this edge can be refilled on the same edge.
- Drop: y_valid with accept false leaves the banks untouched, sets overflow and increments drop_count (saturating). y is ignored whenever y_valid is low.
- FSM IDLE: when full[rd_sel], load word w0 into m_data at the next edge. Set m_valid = 1 and m_index = w0, with m_last = (N == 1); go to STREAM. w0 = 0, or N-1 if REVERSE.
- FSM STREAM: m_data, m_index and m_last hold while m_valid & !m_ready.
  - Handshake on a non-last beat: load the next word. Index steps +1, or -1 if REVERSE. m_last goes high when the next index is the final one.
  - Handshake on the last beat: clear full[rd_sel] and toggle rd_sel.
    - If the new rd_sel bank is full, or is being filled on this edge, load its first word with no bubble and stay in STREAM.
    - Otherwise drop m_valid to 0 and go to IDLE.
- Latency: y_valid sampled at edge k into an empty block gives m_valid = 1 after edge k+1. With m_ready held high, a frame takes N cycles and back-to-back frames have zero gap.
- Capacity: with m_ready low, two frames are held and a third is dropped.
- Frame contents are never mixed: a bank is written only by a full-frame capture.

Test Plan:
- Single frame, N=32, y word i = 32-i, m_ready=1 -> m_valid rises 2 cycles after the y_valid cycle. 32 consecutive beats carry data 32..1 with m_index 0..31; m_last only on index 31; then m_valid = 0 and busy = 0.
- REVERSE=1, same frame -> data 1..32, m_index 31..0, m_last on index 0.
- m_ready toggled 1,0,0,1 pattern -> m_data and m_index stable during stalls; all 32 words delivered exactly once, in order.
- m_ready=0, three y_valid frames A, B, C at cycles 10, 20, 30 -> overflow = 1 and drop_count = 1. Releasing m_ready streams A then B back-to-back, with no gap and no C words.
- Frame B arrives with y_valid on the same cycle as A's last handshake while the other bank holds frame C -> B is accepted into the freed bank; output order is C then B, and drop_count stays 0.
- rst asserted for 1 cycle at beat 5 of a frame -> next cycle all outputs 0. A frame sent after reset streams from word 0.
